// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store controller in front of a
// word-addressed data SRAM. It accepts one request, performs one SRAM access
// (or flags an error without touching the SRAM) and holds the response until
// the consumer takes it.
module mem_access_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  // request side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  // SRAM side
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_web,
  output logic [31:0]       mem_di,
  input  logic [31:0]       mem_do,
  // response side
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          func3_q, func3_d;
  logic [1:0]          off_q, off_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [4:0]          rd_q, rd_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [4:0]          rsp_rd_q, rsp_rd_d;

  logic                accept;
  logic                req_err;
  logic [3:0]          byte_en;
  logic [31:0]         load_data;
  logic [31:0]         byte_shift;
  logic [31:0]         half_shift;

  // Address bits above the SRAM window do not select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign accept = req_valid && req_ready;

  // Legality of the incoming request: unknown width codes and misaligned
  // loads are answered with an error and never reach the SRAM.
  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      req_err = !(req_func3 inside {F3_B, F3_H, F3_W});
    end else begin
      unique case (req_func3)
        F3_B, F3_BU: req_err = 1'b0;
        F3_H, F3_HU: req_err = req_addr[0];
        F3_W:        req_err = (req_addr[1:0] != 2'b00);
        default:     req_err = 1'b1;
      endcase
    end
  end

  // Byte-lane enables for the captured store; lanes follow the byte offset.
  always_comb begin
    byte_en = 4'b0000;
    unique case (func3_q[1:0])
      2'b00:   byte_en = 4'b0001 << off_q;
      2'b01:   byte_en = 4'b0011 << {off_q[1], 1'b0};
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // Load data alignment and sign/zero extension from the raw SRAM word.
  always_comb begin
    byte_shift = mem_do >> {off_q, 3'b000};
    half_shift = mem_do >> {off_q[1], 4'b0000};
    load_data  = 32'h0;
    unique case (func3_q)
      F3_B:    load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
      F3_BU:   load_data = {24'h0, byte_shift[7:0]};
      F3_H:    load_data = {{16{half_shift[15]}}, half_shift[15:0]};
      F3_HU:   load_data = {16'h0, half_shift[15:0]};
      F3_W:    load_data = mem_do;
      default: load_data = 32'h0;
    endcase
  end

  // Next-state and capture logic for the IDLE -> ACCESS -> RESP sequence.
  // NOTE: every signal gets its hold value before the case statement so no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    func3_d  = func3_q;
    off_d    = off_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    rsp_rd_d = rsp_rd_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          func3_d = req_func3;
          off_d   = req_addr[1:0];
          waddr_d = req_addr[ADDR_W+1:2];
          wdata_d = req_wdata;
          rd_d    = req_rd;
          if (req_err) begin
            state_d  = RESP;
            err_d    = 1'b1;
            rdata_d  = 32'h0;
            rsp_rd_d = 5'd0;
          end else begin
            state_d  = ACCESS;
            err_d    = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d  = RESP;
          err_d    = 1'b0;
          rdata_d  = we_q ? 32'h0 : load_data;
          rsp_rd_d = we_q ? 5'd0  : rd_q;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers.
  // NOTE: the data registers are reset too (not just the state) because
  // mem_addr, mem_di and the response fields must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples its pre-edge value regardless of statement order.
      state_q  <= IDLE;
      we_q     <= 1'b0;
      func3_q  <= 3'b000;
      off_q    <= 2'b00;
      waddr_q  <= '0;
      wdata_q  <= 32'h0;
      rd_q     <= 5'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      rsp_rd_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      func3_q  <= func3_d;
      off_q    <= off_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rsp_rd_q <= rsp_rd_d;
    end
  end

  // Outputs are decoded from registered state only, so reset reaches them
  // asynchronously and they stay stable within a state.
  assign req_ready = (state_q == IDLE);
  assign mem_req   = (state_q == ACCESS);
  assign mem_addr  = waddr_q;
  assign mem_di    = wdata_q;
  assign mem_web   = (state_q == ACCESS && we_q) ? ~byte_en : 4'b1111;
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;
  assign rsp_rd    = rsp_rd_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: ADDR_W, 14, word-address width presented to data SRAM.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  access request from execute/memory stage.
REQ-005 req_ready  out  1  block can accept a request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_func3  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, already lane-shifted to its byte position.
REQ-010 req_rd  in  5  load destination register tag.
REQ-011 mem_req  out  1  SRAM access strobe, held until mem_ack.
REQ-012 mem_ack  in  1  SRAM completes access this cycle; mem_do valid for loads.
REQ-013 mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2].
REQ-014 mem_web  out  4  per-byte write enable, active-low.
REQ-015 mem_di  out  32  write data to SRAM.
REQ-016 mem_do  in  32  read data from SRAM.
REQ-017 rsp_valid  out  1  response available.
REQ-018 rsp_ready  in  1  consumer takes response.
REQ-019 rsp_rdata  out  32  extended load data; 0 for stores.
REQ-020 rsp_rd  out  5  tag of completed load; 0 for stores.
REQ-021 rsp_err  out  1  misaligned or illegal func3; no SRAM access made.

Function
REQ-022 FSM states SHALL be IDLE, ACCESS, RESP; req_ready = (state==IDLE).
REQ-023 Handshake on req_valid&req_ready; request fields (we, func3, addr[1:0], word addr, wdata, rd) captured into registers at that edge.
REQ-024 Error check at accept: lh/lhu with addr[0]=1, lw with addr[1:0]!=0, load func3 in {011,110,111}, store func3 not in {000,001,010} -> err.
REQ-025 IDLE -> RESP on accepted err request (rsp_valid next cycle, rsp_err=1, rdata=0, rd=0); IDLE -> ACCESS on accepted legal request.
REQ-026 In ACCESS: mem_req=1, mem_addr/mem_di/mem_web driven from captured registers, stable until mem_ack.
REQ-027 Store byte enables, lane k = bits [8k+7:8k], k=addr[1:0]: sb -> lane k; sh -> lanes {addr[1]*2, addr[1]*2+1}; sw -> all; mem_web = ~enables.
REQ-028 Loads: mem_web=4'b1111; outside ACCESS mem_req=0, mem_web=4'b1111.
REQ-029 ACCESS -> RESP on mem_ack; load data extracted from mem_do at that edge: lb/lbu byte at lane k, lh/lhu halfword at lane addr[1]*2, sign- (b,h) or zero-extended (bu,hu) to 32 bits.
REQ-030 RESP: rsp_valid=1, outputs held stable; RESP -> IDLE on rsp_ready.
REQ-031 Minimum latency: accept at edge T, mem_req high during T..T+1, mem_ack in first ACCESS cycle -> rsp_valid in cycle after; back-to-back accepts no closer than 3 cycles.
REQ-032 req_valid while not ready SHALL be ignored (no capture); upstream holds request.
REQ-033 rsp_ready while rsp_valid=0 SHALL have no effect; mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, mem_req=0, mem_web=4'b1111, rsp_valid=0, rsp_err=0, rsp_rdata=0, rsp_rd=0, mem_addr=0, mem_di=0.
REQ-035 Reset during ACCESS or RESP SHALL abandon the transaction; no response after release; req_ready=1 first cycle after rst_n rises.

Verification
REQ-036 sb addr=0x103, wdata=0xAB000000, mem_ack after 2 cycles -> mem_addr=0x40, mem_web=4'b0111 for 3 cycles, then rsp_valid, rsp_err=0, rsp_rd=0.
REQ-037 lb addr=0x2, mem_do=0x0080_0000, rd=5 -> rsp_rdata=0xFFFFFF80, rsp_rd=5; lbu same -> 0x00000080.
REQ-038 lhu addr=0x6, mem_do=0x8001_1234 -> rsp_rdata=0x00008001; lh same -> 0xFFFF8001.
REQ-039 lw addr=0x5 -> mem_req never asserted, rsp_valid next cycle, rsp_err=1, rsp_rdata=0.
REQ-040 rsp_ready held low 4 cycles in RESP -> outputs stable, req_ready=0, new req_valid ignored; rsp_ready=1 -> IDLE next cycle.
REQ-041 rst_n pulsed low mid-ACCESS with mem_ack pending -> mem_req drops asynchronously, no rsp_valid after release, next request served normally.
